// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: bus bundle for ram_stream_reader.
// Groups the command channel, the RAM read port and the AXI-Stream output.
//   slave  : view used by ram_stream_reader (takes commands, drives RAM address and stream)
//   master : view used by the surrounding logic (issues commands, supplies RAM data, sinks stream)
interface ram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
);
    // Command channel
    logic                  s_cmd_valid;
    logic                  s_cmd_ready;
    logic [ADDR_WIDTH-1:0] s_cmd_addr;
    logic [LEN_WIDTH-1:0]  s_cmd_len;

    // RAM read port
    logic                  ram_write_enable;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_out;

    // Output stream
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_len, ram_data_out, m_axis_tready,
        output s_cmd_ready, ram_write_enable, ram_address,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_len, ram_data_out, m_axis_tready,
        input  s_cmd_ready, ram_write_enable, ram_address,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a (start address, word count) range out of a
// single-port RAM with registered read data and streams the words out as
// AXI-Stream with backpressure and tlast on the final word.
//
// Ports:
//   clk   - single clock
//   rst   - synchronous active-low reset
//   bus   - ram_stream_reader_if.slave: command, RAM read port, output stream
//   busy  - high whenever the controller is not idle
//   done  - one-cycle pulse when a command completes
//
// Build option: define RAM_OUT_REG_EN when the RAM has an extra output
// register; the read tag pipeline grows to 3 stages and the output FIFO to 8.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    ram_stream_reader_if.slave bus,
    output logic               busy,
    output logic               done
);

`ifdef RAM_OUT_REG_EN
    localparam int unsigned PIPE_STAGES = 3;
    localparam int unsigned FIFO_DEPTH  = 8;
`else
    localparam int unsigned PIPE_STAGES = 2;
    localparam int unsigned FIFO_DEPTH  = 4;
`endif
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH:0] DEPTH_LIM = (CNT_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t                  r_state;
    logic                    r_cmd_ready;
    logic                    r_busy;
    logic                    r_done;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [ADDR_WIDTH-1:0]   r_ram_addr;
    logic [LEN_WIDTH-1:0]    r_rem;

    logic [PIPE_STAGES-1:0]  r_tag_v;
    logic [PIPE_STAGES-1:0]  r_tag_last;

    logic [DATA_WIDTH-1:0]   r_q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   r_q_last;
    logic [CNT_WIDTH-1:0]    r_count;
    logic                    r_tvalid;

    logic                    w_cmd_fire;
    logic                    w_issue;
    logic                    w_issue_last;
    logic [ADDR_WIDTH-1:0]   w_issue_addr;
    logic [CNT_WIDTH-1:0]    w_in_flight;
    logic [CNT_WIDTH:0]      w_pending;
    logic                    w_credit;
    logic                    w_push;
    logic                    w_pop;
    logic [DATA_WIDTH-1:0]   w_q_data_nxt [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   w_q_last_nxt;
    logic [CNT_WIDTH-1:0]    w_count_pop;
    logic [CNT_WIDTH-1:0]    w_count_nxt;

    assign bus.s_cmd_ready      = r_cmd_ready;
    assign bus.ram_write_enable = 1'b0;
    assign bus.ram_address      = r_ram_addr;
    assign bus.m_axis_tdata     = r_q_data[0];
    assign bus.m_axis_tlast     = r_q_last[0];
    assign bus.m_axis_tvalid    = r_tvalid;
    assign busy                 = r_busy;
    assign done                 = r_done;

    // Reads outstanding in the tag pipeline
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            w_in_flight = w_in_flight + CNT_WIDTH'(r_tag_v[i]);
        end
    end

    // Credit counts every word already owed to the FIFO so it can never overflow
    assign w_pending = (CNT_WIDTH + 1)'(w_in_flight) + (CNT_WIDTH + 1)'(r_count);
    assign w_credit  = (w_pending < DEPTH_LIM);
    assign w_push    = r_tag_v[PIPE_STAGES-1];
    assign w_pop     = r_tvalid && bus.m_axis_tready;

    // Issue decision; the first read goes out on the command handshake itself
    always_comb begin
        w_cmd_fire   = r_cmd_ready && bus.s_cmd_valid;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_issue_addr = r_cur_addr;
        case (r_state)
            ST_IDLE: begin
                w_issue      = w_cmd_fire && (bus.s_cmd_len != '0);
                w_issue_last = (bus.s_cmd_len == LEN_WIDTH'(1));
                w_issue_addr = bus.s_cmd_addr;
            end
            ST_READ: begin
                w_issue      = (r_rem != '0) && w_credit;
                w_issue_last = (r_rem == LEN_WIDTH'(1));
            end
            default: ;
        endcase
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_addr  <= '0;
            r_ram_addr  <= '0;
            r_rem       <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_issue) begin
                r_ram_addr <= w_issue_addr;
                r_cur_addr <= w_issue_addr + ADDR_WIDTH'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        if (bus.s_cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cmd_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_rem       <= bus.s_cmd_len - LEN_WIDTH'(1);
                            r_state     <= w_issue_last ? ST_DRAIN : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_rem <= r_rem - LEN_WIDTH'(1);
                        if (w_issue_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Empty FIFO with nothing in flight means the tlast beat has left
                    if ((r_count == '0) && (w_in_flight == '0)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read tag pipeline: marks which RAM output cycles carry requested data
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag_v    <= '0;
            r_tag_last <= '0;
        end else begin
            r_tag_v    <= {r_tag_v[PIPE_STAGES-2:0], w_issue};
            r_tag_last <= {r_tag_last[PIPE_STAGES-2:0], w_issue && w_issue_last};
        end
    end

    // Shift FIFO next state: entry 0 is the output register
    always_comb begin
        w_q_data_nxt = r_q_data;
        w_q_last_nxt = r_q_last;
        w_count_pop  = r_count;
        if (w_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                w_q_data_nxt[i] = r_q_data[i+1];
                w_q_last_nxt[i] = r_q_last[i+1];
            end
            w_q_data_nxt[FIFO_DEPTH-1] = '0;
            w_q_last_nxt[FIFO_DEPTH-1] = 1'b0;
            w_count_pop = r_count - CNT_WIDTH'(1);
        end
        w_count_nxt = w_count_pop;
        if (w_push) begin
            w_q_data_nxt[PTR_WIDTH'(w_count_pop)] = bus.ram_data_out;
            w_q_last_nxt[PTR_WIDTH'(w_count_pop)] = r_tag_last[PIPE_STAGES-1];
            w_count_nxt = w_count_pop + CNT_WIDTH'(1);
        end
    end

    // Output FIFO storage
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_data[i] <= '0;
            end
            r_q_last <= '0;
            r_count  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            r_q_data <= w_q_data_nxt;
            r_q_last <= w_q_last_nxt;
            r_count  <= w_count_nxt;
            r_tvalid <= (w_count_nxt != '0);
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench for ram_stream_reader with a RAM model.
module tb_ram_stream_reader;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 16;
    localparam int unsigned LW = 16;
`ifdef RAM_OUT_REG_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 2;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic done;

    ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // RAM model: registered read (plus output register when enabled)
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
`ifdef RAM_OUT_REG_EN
    logic [DW-1:0] ram_q2;
    always @(posedge clk) begin
        ram_q  <= mem[bus.ram_address];
        ram_q2 <= ram_q;
    end
    assign bus.ram_data_out = ram_q2;
`else
    always @(posedge clk) ram_q <= mem[bus.ram_address];
    assign bus.ram_data_out = ram_q;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    beat_t       exp_q[$];
    int unsigned done_q[$];
    int          rdy_mode = 0;
    int          rdy_k = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // tready driver: constant, random, or scripted backpressure pattern
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.m_axis_tready = 1'b1;
            1: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            default: begin
                if (rdy_k < 12)      bus.m_axis_tready = ((rdy_k % 2) == 0);
                else if (rdy_k < 22) bus.m_axis_tready = 1'b0;
                else                 bus.m_axis_tready = 1'b1;
                rdy_k++;
            end
        endcase
    end

    // Monitor: pops the scoreboard on each beat and checks stall stability
    logic          stall_pend = 1'b0;
    logic [DW-1:0] stall_d;
    logic          stall_l;
    logic          prev_done = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            stall_pend = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("hold_valid", 64'(bus.m_axis_tvalid), 64'd1);
                chk("hold_data", bus.m_axis_tdata, stall_d);
                chk("hold_last", 64'(bus.m_axis_tlast), 64'(stall_l));
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: actual data=%h required no beat", bus.m_axis_tdata);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", bus.m_axis_tdata, b.d);
                    chk("beat_last", 64'(bus.m_axis_tlast), 64'(b.l));
                end
            end
            stall_pend = bus.m_axis_tvalid && !bus.m_axis_tready;
            stall_d    = bus.m_axis_tdata;
            stall_l    = bus.m_axis_tlast;
            if (done) begin
                chk("done_pulse_width", 64'(prev_done), 64'd0);
                done_q.push_back(cyc);
            end
            prev_done = done;
        end
    end

    // Issue one command; expected beats come from the memory image directly
    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n, output int unsigned hs);
        bit ok;
        logic [AW-1:0] ad;
        beat_t b;
        ok = 1'b0;
        hs = 0;
        @(posedge clk);
        #1;
        bus.s_cmd_valid = 1'b1;
        bus.s_cmd_addr  = a;
        bus.s_cmd_len   = n;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.s_cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("cmd_ready_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
            bus.s_cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hs = cyc;
        bus.s_cmd_valid = 1'b0;
        if (n != '0) begin
            chk("first_ram_address", 64'(bus.ram_address), 64'(a));
            chk("write_enable", 64'(bus.ram_write_enable), 64'd0);
        end
        for (int i = 0; i < int'(n); i++) begin
            ad  = a + AW'(i);
            b.d = mem[ad];
            b.l = (i == int'(n) - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_dones(input int target, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (done_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs;
        int unsigned hs2;
        int base;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, 32'(i)};
        bus.s_cmd_valid = 1'b0;
        bus.s_cmd_addr  = '0;
        bus.s_cmd_len   = '0;
        bus.m_axis_tready = 1'b1;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(bus.s_cmd_ready), 64'd0);
        chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk("rst_tdata", bus.m_axis_tdata, 64'd0);
        chk("rst_ram_address", 64'(bus.ram_address), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 64'(bus.s_cmd_ready), 64'd1);

        // Basic read with latency and full-rate check
        rdy_mode = 0;
        base = done_q.size();
        send_cmd(16'h0010, 16'd8, hs);
        for (int k = 0; k <= int'(LAT); k++) begin
            @(negedge clk);
            chk("first_tvalid_latency", 64'(bus.m_axis_tvalid), 64'(k == int'(LAT)));
        end
        chk("busy_during_read", 64'(busy), 64'd1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("full_rate_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        end
        wait_dones(base + 1, "basic_done");
        chk("basic_queue_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: alternating ready, then a long stall
        rdy_k = 0;
        rdy_mode = 2;
        base = done_q.size();
        send_cmd(AW'($urandom), 16'd16, hs);
        wait_dones(base + 1, "bp_done");
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;

        // Address wrap
        base = done_q.size();
        send_cmd(16'hFFFE, 16'd4, hs);
        wait_dones(base + 1, "wrap_done");
        chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

        // Zero length
        base = done_q.size();
        send_cmd(AW'($urandom), 16'd0, hs);
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("zero_cmd_ready", 64'(bus.s_cmd_ready), 64'd1);
        @(negedge clk);
        chk("zero_done_off", 64'(done), 64'd0);
        chk("zero_cmd_ready2", 64'(bus.s_cmd_ready), 64'd1);
        chk("zero_tvalid2", 64'(bus.m_axis_tvalid), 64'd0);

        // Back-to-back: len 1 then len 3
        base = done_q.size();
        send_cmd(AW'($urandom), 16'd1, hs);
        send_cmd(AW'($urandom), 16'd3, hs2);
        wait_dones(base + 2, "b2b_two_dones");
        if (done_q.size() >= base + 2) begin
            chk("b2b_handshake_after_done", 64'(hs2 >= done_q[base] + 2), 64'd1);
        end
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // Randomized commands under random backpressure
        rdy_mode = 1;
        for (int t = 0; t < 8; t++) begin
            base = done_q.size();
            send_cmd(AW'($urandom), LW'($urandom_range(1, 40)), hs);
            wait_dones(base + 1, "rand_done");
        end
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a long read
        send_cmd(AW'($urandom), 16'd100, hs);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("midrst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
            chk("midrst_busy", 64'(busy), 64'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cmd_ready", 64'(bus.s_cmd_ready), 64'd1);
        repeat (10) @(posedge clk);
        base = done_q.size();
        send_cmd(AW'($urandom), 16'd10, hs);
        wait_dones(base + 1, "post_rst_done");

        repeat (5) @(posedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side consumer of the single-port RAM block (`ram_block`): accepts a (start address, word count) command and drives the RAM address.
- Captures the RAM's registered read data and emits it as an AXI-Stream with full backpressure and tlast on the final word.
- Sits between the RAM payload buffer and the RoCE TX framing logic; sustains 1 word/cycle when m_axis_tready is held high.

Parameters:
- DATA_WIDTH, 64, RAM word / stream width in bits.
- ADDR_WIDTH, 16, RAM address width in bits.
- LEN_WIDTH, 16, command word-count width in bits.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command ready; high only in IDLE.
- s_cmd_addr  in  ADDR_WIDTH  first RAM word address.
- s_cmd_len  in  LEN_WIDTH  number of words to read.
- ram_write_enable  out  1  constant 0; the block is read-only.
- ram_address  out  ADDR_WIDTH  registered RAM address.
- ram_data_out  in  DATA_WIDTH  RAM registered read data.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  final word of the command.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values: s_cmd_ready=0 during reset and 1 in the first cycle after it; ram_address=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; busy=0; done=0. All other state clears: FIFO, in-flight tags, counters.
- Reset mid-operation discards in-flight reads and buffered words; no further beats are emitted.
- States:
  - IDLE: s_cmd_ready=1. On handshake, latch addr and rem=len. If len=0, pulse done on the next cycle and stay in IDLE (no beats). Otherwise go to READ.
  - READ: issue one read per cycle while rem>0 and credit is available (in_flight + fifo_count < FIFO_DEPTH).
    - Issue = load ram_address with cur_addr, then cur_addr += 1 (mod 2**ADDR_WIDTH), rem -= 1.
    - Tag the issue with is_last = (rem==1).
    - When the last read is issued, go to DRAIN.
  - DRAIN: no new issues. When the FIFO is empty, no reads are in flight and the tlast beat has handshaken, pulse done for 1 cycle and return to IDLE.
- Read latency: the tag moves through a 2-stage valid/last shift register (address cycle, RAM data cycle). At the end of the second stage, ram_data_out is pushed into the output FIFO with its last flag.
- ram_address only changes on issue; between issues it holds its value. The RAM's free-running data_out is ignored unless tagged.
- Output FIFO: FIFO_DEPTH=4, first-word-fall-through registered outputs. m_axis_tvalid = FIFO not empty.
- A beat transfers when tvalid && tready. tdata and tlast stay stable while tvalid && !tready.
- Latency: command handshake at edge E0 → first ram_address valid after E0 → first m_axis_tvalid high after E2.
- The credit rule guarantees the FIFO never overflows; pushes and pops in the same cycle keep the count unchanged.
- Address wrap: addr + len beyond 2**ADDR_WIDTH - 1 wraps to 0 silently.
- A new command is not accepted until done has pulsed; done and the next s_cmd_ready are in consecutive cycles.

Optional Feature:
- Macro: RAM_OUT_REG_EN.
- Defined: the RAM has an extra output register. The tag pipeline becomes 3 stages and FIFO_DEPTH becomes 8; first tvalid appears after E3. Full-rate streaming is preserved.
- Undefined: 2-stage tag pipeline, FIFO_DEPTH=4, as above.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-stream (e.g. during a 100-word read).
  - Required: tvalid=0 and busy=0 during reset, s_cmd_ready=1 after release, and a fresh command then reads correctly.
- Basic read: RAM preloaded with mem[i]=i; cmd addr=0x10, len=8, tready=1.
  - Required: beats 0x10..0x17 on 8 consecutive cycles, tlast on 0x17, first tvalid 2 cycles after handshake, then done pulse.
- Backpressure: len=16, tready toggling 1010… then low for 10 cycles.
  - Required: no lost or duplicated words, data held stable while stalled, tlast only on word 16.
- Wrap: addr=0xFFFE, len=4 (ADDR_WIDTH=16).
  - Required: data from addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, in that order.
- Zero length: cmd len=0.
  - Required: no tvalid, done pulses 1 cycle after handshake, s_cmd_ready stays 1.
- Back-to-back: cmd len=1 then cmd len=3.
  - Required: tlast on beat 1 and beat 4, two done pulses, second handshake no earlier than the cycle after the first done.
